// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the default datapath width.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// restoring compare-subtract-shift for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    hi_o    = hi_i;
    lo_o    = lo_i;
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    // Partial remainder is WIDTH+1 bits wide; when it is >= divisor the true
    // difference is below 2^WIDTH, so a WIDTH-bit modular subtract is exact.
    shifted = {hi_i, lo_i[WIDTH-1]};
    ge      = shifted >= {1'b0, b_i};
    diff    = shifted[WIDTH-1:0] - b_i;
    if (is_div_i) begin
      hi_o = ge ? diff : shifted[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ge};
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Fixed 34-cycle sequence: accept, 32 iterations, sign fix and commit.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] acc_hi_d;
  logic [WIDTH-1:0] acc_lo_d;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             op_div;
  logic             op_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    sign_a    = op_signed & src_a[WIDTH-1];
    sign_b    = op_signed & src_b[WIDTH-1];
    mag_a     = sign_a ? -src_a : src_a;
    mag_b     = sign_b ? -src_b : src_b;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .b_i      (b_q),
    .hi_o     (acc_hi_d),
    .lo_o     (acc_lo_d)
  );

  // Sign correction applied to the unsigned magnitude result at FIX.
  always_comb begin
    prod   = {acc_hi_q, acc_lo_q};
    fix_hi = acc_hi_q;
    fix_lo = acc_lo_q;
    if (!is_div_q) begin
      if (neg_res_q) prod = -prod;
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else begin
      if (neg_res_q) fix_lo = -acc_lo_q;
      if (neg_rem_q) fix_hi = -acc_hi_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too; they are plain flops, not a memory array, so clearing them is cheap and keeps X out of simulation.
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_hi) hi_q <= wdata;
          if (wr_lo) lo_q <= wdata;
          if (start && !flush) begin
            state_q   <= CALC;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            is_div_q  <= op_div;
            // Divide by zero keeps the all-ones quotient the iteration produces.
            neg_res_q <= (sign_a ^ sign_b) & ~(op_div && src_b == '0);
            neg_rem_q <= op_div & sign_a;
            b_q       <= mag_b;
            acc_hi_q  <= '0;
            acc_lo_q  <= mag_a;
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a driver pushes reference results,
// a monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 33;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic         wr_hi = 1'b0;
  logic         wr_lo = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           cyc    = 0;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_hi   = '0;
  logic [W-1:0] m_lo   = '0;

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .flush (flush),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural operands.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    logic [63:0] r;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    e.cyc = 0;
    e.hi  = '0;
    e.lo  = '0;
    case (o)
      OP_MULT:  begin r = sa * sb; e.hi = r[63:32]; e.lo = r[31:0]; end
      OP_MULTU: begin r = {32'd0, a} * {32'd0, b}; e.hi = r[63:32]; e.lo = r[31:0]; end
      default: begin
        if (b == '0) begin
          e.lo = '1;
          e.hi = a;
        end else if (o == OP_DIV) begin
          r = sa / sb; e.lo = r[31:0];
          r = sa % sb; e.hi = r[31:0];
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Call at a negedge while the unit is idle; returns just after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e     = model(o, a, b);
      e.cyc = cyc + LAT;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    check(name, done, 1'b1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", done, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("done_cycle", cyc, e.cyc);
        m_hi = e.hi;
        m_lo = e.lo;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    int           nb;
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] snap_hi;
    logic [W-1:0] snap_lo;

    repeat (2) @(negedge clk);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU max x max with busy length and done pulse width
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) nb++;
    end
    check("busy_cycles", nb, LAT);
    check("done_seen", done, 1'b1);
    @(negedge clk);
    check("done_pulse_width", done, 1'b0);

    // Back-to-back: second start issued in the done cycle
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1);
    wait_done("done_mult_neg");
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1);
    wait_done("done_mult_b2b");

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1);
    wait_done("done_div_neg");
    issue(OP_DIVU, 32'd7, 32'd2, 1);
    wait_done("done_divu");
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done("done_div_ovf");
    issue(OP_DIVU, 32'd5, 32'd0, 1);
    wait_done("done_divu_zero");
    issue(OP_DIV, 32'hFFFF_FFF0, 32'd0, 1);
    wait_done("done_div_zero");

    // Flush mid-CALC: ignored restart at cycle 5, ignored MTHI, flush at cycle 10
    @(negedge clk);
    snap_hi = m_hi;
    snap_lo = m_lo;
    issue(OP_DIVU, 32'd100, 32'd7, 0);
    repeat (3) @(negedge clk);
    wr_hi = 1'b1;
    wdata = 32'h1234_5678;
    @(negedge clk);
    wr_hi = 1'b0;
    issue(OP_MULTU, 32'd9, 32'd9, 0);
    repeat (5) @(negedge clk);
    check("busy_before_flush", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 1'b0);
    check("flush_hi", hi, snap_hi);
    check("flush_lo", lo, snap_lo);
    repeat (40) @(negedge clk);

    // MTHI / MTLO in IDLE
    wr_hi = 1'b1;
    wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    wr_hi = 1'b0;
    @(negedge clk);
    check("mthi_idle", hi, 32'h1234_5678);
    check("mthi_lo_kept", lo, snap_lo);
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wdata = 32'hA5A5_5A5A;
    @(posedge clk);
    #1;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    @(negedge clk);
    check("mthi_both", hi, 32'hA5A5_5A5A);
    check("mtlo_both", lo, 32'hA5A5_5A5A);

    // Flush in IDLE blocks start that cycle
    flush = 1'b1;
    issue(OP_MULTU, 32'd2, 32'd2, 0);
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", busy, 1'b0);

    // MTLO together with start: write lands, then FIX overwrites
    wr_lo = 1'b1;
    wdata = 32'hCAFE_F00D;
    issue(OP_MULTU, 32'd6, 32'd7, 1);
    wr_lo = 1'b0;
    @(negedge clk);
    check("mtlo_with_start", lo, 32'hCAFE_F00D);
    wait_done("done_after_mtlo");

    // Flush exactly in FIX: no commit, no done
    @(negedge clk);
    snap_hi = m_hi;
    snap_lo = m_lo;
    issue(OP_DIV, 32'hFFFF_FF00, 32'd3, 0);
    repeat (LAT) @(negedge clk);
    check("busy_in_fix", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("fix_flush_busy", busy, 1'b0);
    check("fix_flush_hi", hi, snap_hi);
    check("fix_flush_lo", lo, snap_lo);
    repeat (3) @(negedge clk);

    // Randomised ops, with occasional ignored start pulses while busy
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      issue(ro, ra, rb, 1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        issue(2'($urandom), $urandom, $urandom, 0);
      end
      wait_done("done_random");
    end

    // Async reset mid-CALC, then a fresh operation
    @(negedge clk);
    issue(OP_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_hi", hi, 0);
    check("midreset_lo", lo, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(OP_MULTU, 32'd3, 32'd4, 1);
    wait_done("done_after_reset");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
- Sits directly downstream of the register file: operands come from its two read ports (rs → src_a, rt → src_b).
- MFHI/MFLO results return to the register-file write port via the writeback mux.
- Executes MULT, MULTU, DIV and DIVU in a fixed 34-cycle sequence, with a start/busy/done handshake and a flush for exceptions.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  WIDTH  rs operand (multiplicand / dividend).
- src_b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  synchronous abort of an in-flight operation.
- wr_hi  in  1  MTHI write enable.
- wr_lo  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress; used by the hazard unit to stall.
- done  out  1  one-cycle pulse when HI/LO has been updated.
- hi  out  WIDTH  HI register, for MFHI.
- lo  out  WIDTH  LO register, for MFLO.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hi=0, lo=0, busy=0, done=0; counter and datapath registers cleared.
  - Applies immediately, including mid-operation; nothing is committed.
- States: IDLE → CALC → FIX → IDLE.
- IDLE:
  - start=1 at edge E0 latches op and operands.
  - Signed ops (MULT, DIV) latch operand magnitudes plus result sign flags; unsigned ops latch operands as-is.
  - Counter=0; busy=1 after E0.
- CALC: one iteration per edge, E1..E32, counter 0..31.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, remainder WIDTH+1 bits.
  - Leave CALC when counter==WIDTH-1.
- FIX, at edge E33:
  - Apply sign correction: product negated if sign(a)≠sign(b); quotient negated if signs differ; remainder takes sign(a).
  - Write HI/LO: multiply → HI=upper, LO=lower; divide → LO=quotient, HI=remainder.
  - busy=0 and done=1 after E33; done clears after E34.
  - Return to IDLE.
- Latency: exactly 33 edges from start acceptance to HI/LO update, for every op and operand value. A new start is accepted in the same cycle done is high.
- Divide by zero: no trap. LO=0xFFFFFFFF, HI=dividend (src_a as supplied); same latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude path; it must not be special-cased into anything else.
- start while busy: ignored; no queueing.
- flush:
  - While busy: state=IDLE next edge, busy=0, no done, HI/LO unchanged.
  - In FIX: flush wins and HI/LO are not written.
  - In IDLE: no effect, and start is not accepted that cycle.
- wr_hi/wr_lo:
  - Take effect at the next edge, only in IDLE; ignored while busy (the hazard unit stalls MTHI/MTLO behind busy).
  - Both may be asserted together.
  - In IDLE, wr_hi/wr_lo and start in the same cycle: the write applies; the operation later overwrites at FIX.
- hi/lo are registered outputs, with no combinational bypass of in-flight results.

Decomposition:
- Shared package: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum (IDLE, CALC, FIX), WIDTH default.
- One sub-module: muldiv_step, a combinational single-iteration datapath (add-shift / compare-subtract-shift) selected by a mul/div flag.
- Top level holds the FSM, counter, sign flags, HI/LO and the handshake.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; busy high for 33 cycles; done pulses exactly one cycle, 33 edges after acceptance.
- MULT 0xFFFFFFFD(−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; then back-to-back start in the done cycle with MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9(−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 2 → LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0; DIVU 5 / 0 → LO=0xFFFFFFFF, HI=5, same 33-edge latency.
- Start DIVU, pulse start again at cycle 5 (ignored), flush at cycle 10 → busy=0 next cycle, no done, HI/LO keep prior values; MTHI 0x12345678 while busy is ignored, then in IDLE → hi=0x12345678 after one edge.
- rst_n low mid-CALC → hi=lo=0, busy=done=0 immediately; release rst_n, start MULTU 3 × 4 → LO=12, HI=0.
